// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl
// Holds the three rotor positions, applies Enigma stepping (with the
// double-step anomaly) per accepted keypress and walks one shared rotor
// lookup through rotors 1, 2 and 3. Valid/ready handshakes on both sides.
module enigma_step_ctrl #(
    parameter logic [4:0] NOTCH1 = 5'd16,
    parameter logic [4:0] NOTCH2 = 5'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    input  logic [4:0] in_letter_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [4:0] out_letter_o,
    output logic       out_err_o,
    input  logic       out_ready_i,
    input  logic       cfg_load_i,
    input  logic [4:0] cfg_pos1_i,
    input  logic [4:0] cfg_pos2_i,
    input  logic [4:0] cfg_pos3_i,
    output logic [4:0] pos1_o,
    output logic [4:0] pos2_o,
    output logic [4:0] pos3_o,
    output logic       lu_en_o,
    output logic [1:0] lu_sel_o,
    output logic [4:0] lu_in_o,
    output logic [4:0] lu_rot_o,
    input  logic [4:0] lu_out_i
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STEP = 3'd1,
        F1   = 3'd2,
        F2   = 3'd3,
        F3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
    logic [4:0] letter_q, letter_d;
    logic       out_valid_q, out_valid_d;
    logic [4:0] out_letter_q, out_letter_d;
    logic       out_err_q, out_err_d;
    logic       lu_en_q, lu_en_d;
    logic [1:0] lu_sel_q, lu_sel_d;
    logic [4:0] lu_in_q, lu_in_d;
    logic [4:0] lu_rot_q, lu_rot_d;
    logic       carry2_s, carry3_s;
    logic [4:0] pos1_step_s;

    // (v + 1) mod 26 using a 6-bit intermediate and compare-subtract
    function automatic logic [4:0] inc26(input logic [4:0] v);
        logic [5:0] s;
        s = {1'b0, v} + 6'd1;
        if (s >= 6'd26) begin
            s = s - 6'd26;
        end else begin
            s = s;
        end
        return s[4:0];
    endfunction

    // Fold configuration values 26..31 back into 0..5
    function automatic logic [4:0] red26(input logic [4:0] v);
        logic [5:0] s;
        s = {1'b0, v};
        if (s >= 6'd26) begin
            s = s - 6'd26;
        end else begin
            s = s;
        end
        return s[4:0];
    endfunction

    // A stage result of 0 represents letter 26
    function automatic logic [4:0] fix26(input logic [4:0] v);
        return (v == 5'd0) ? 5'd26 : v;
    endfunction

    // Letter codes 1..26 are legal, everything else is an error
    function automatic logic letter_ok(input logic [4:0] v);
        return (v >= 5'd1) && (v <= 5'd26);
    endfunction

    assign carry2_s    = (pos1_q == NOTCH1) || (pos2_q == NOTCH2);
    assign carry3_s    = (pos2_q == NOTCH2);
    assign pos1_step_s = inc26(pos1_q);

    assign in_ready_o   = (state_q == IDLE) && !cfg_load_i;
    assign out_valid_o  = out_valid_q;
    assign out_letter_o = out_letter_q;
    assign out_err_o    = out_err_q;
    assign pos1_o       = pos1_q;
    assign pos2_o       = pos2_q;
    assign pos3_o       = pos3_q;
    assign lu_en_o      = lu_en_q;
    assign lu_sel_o     = lu_sel_q;
    assign lu_in_o      = lu_in_q;
    assign lu_rot_o     = lu_rot_q;

    // Next-state and next-output logic; lookup port values are prepared one
    // cycle ahead so they leave the block straight from registers
    always_comb begin
        state_d      = state_q;
        pos1_d       = pos1_q;
        pos2_d       = pos2_q;
        pos3_d       = pos3_q;
        letter_d     = letter_q;
        out_valid_d  = out_valid_q;
        out_letter_d = out_letter_q;
        out_err_d    = out_err_q;
        lu_en_d      = 1'b0;
        lu_sel_d     = 2'd0;
        lu_in_d      = 5'd0;
        lu_rot_d     = 5'd0;
        case (state_q)
            IDLE: begin
                if (cfg_load_i) begin
                    pos1_d = red26(cfg_pos1_i);
                    pos2_d = red26(cfg_pos2_i);
                    pos3_d = red26(cfg_pos3_i);
                end else if (in_valid_i) begin
                    letter_d = in_letter_i;
                    state_d  = STEP;
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (letter_ok(letter_q)) begin
                    pos1_d   = pos1_step_s;
                    pos2_d   = carry2_s ? inc26(pos2_q) : pos2_q;
                    pos3_d   = carry3_s ? inc26(pos3_q) : pos3_q;
                    lu_en_d  = 1'b1;
                    lu_sel_d = 2'd0;
                    lu_in_d  = letter_q;
                    lu_rot_d = pos1_step_s;
                    state_d  = F1;
                end else begin
                    out_valid_d  = 1'b1;
                    out_letter_d = 5'd0;
                    out_err_d    = 1'b1;
                    state_d      = DONE;
                end
            end
            F1: begin
                lu_en_d  = 1'b1;
                lu_sel_d = 2'd1;
                lu_in_d  = fix26(lu_out_i);
                lu_rot_d = pos2_q;
                state_d  = F2;
            end
            F2: begin
                lu_en_d  = 1'b1;
                lu_sel_d = 2'd2;
                lu_in_d  = fix26(lu_out_i);
                lu_rot_d = pos3_q;
                state_d  = F3;
            end
            F3: begin
                out_valid_d  = 1'b1;
                out_letter_d = fix26(lu_out_i);
                out_err_d    = 1'b0;
                state_d      = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, position and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pos1_q       <= 5'd0;
            pos2_q       <= 5'd0;
            pos3_q       <= 5'd0;
            letter_q     <= 5'd0;
            out_valid_q  <= 1'b0;
            out_letter_q <= 5'd0;
            out_err_q    <= 1'b0;
            lu_en_q      <= 1'b0;
            lu_sel_q     <= 2'd0;
            lu_in_q      <= 5'd0;
            lu_rot_q     <= 5'd0;
        end else begin
            state_q      <= state_d;
            pos1_q       <= pos1_d;
            pos2_q       <= pos2_d;
            pos3_q       <= pos3_d;
            letter_q     <= letter_d;
            out_valid_q  <= out_valid_d;
            out_letter_q <= out_letter_d;
            out_err_q    <= out_err_d;
            lu_en_q      <= lu_en_d;
            lu_sel_q     <= lu_sel_d;
            lu_in_q      <= lu_in_d;
            lu_rot_q     <= lu_rot_d;
        end
    end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl; the shared lookup is modelled as
// lu_out = (lu_in + lu_rot) mod 26.
module tb_enigma_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_letter = 5'd0;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_letter;
    logic       out_err;
    logic       out_ready = 1'b0;
    logic       cfg_load = 1'b0;
    logic [4:0] cfg_pos1 = 5'd0, cfg_pos2 = 5'd0, cfg_pos3 = 5'd0;
    logic [4:0] pos1, pos2, pos3;
    logic       lu_en;
    logic [1:0] lu_sel;
    logic [4:0] lu_in, lu_rot, lu_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign lu_out = 5'((int'(lu_in) + int'(lu_rot)) % 26);

    enigma_step_ctrl #(.NOTCH1(5'd16), .NOTCH2(5'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_letter_i(in_letter), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_letter_o(out_letter), .out_err_o(out_err),
        .out_ready_i(out_ready),
        .cfg_load_i(cfg_load), .cfg_pos1_i(cfg_pos1), .cfg_pos2_i(cfg_pos2),
        .cfg_pos3_i(cfg_pos3),
        .pos1_o(pos1), .pos2_o(pos2), .pos3_o(pos3),
        .lu_en_o(lu_en), .lu_sel_o(lu_sel), .lu_in_o(lu_in), .lu_rot_o(lu_rot),
        .lu_out_i(lu_out)
    );

    typedef struct {
        bit cfg;
        int c1, c2, c3;
        int letter;
        int p1, p2, p3;
        int s1, s2;
        int res;
        int err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  lat, nlu;
        int  lin[3], lrot[3], lsel[3];
        bit  ok;
        ok = (v.letter >= 1) && (v.letter <= 26);
        @(negedge clk);
        if (v.cfg) begin
            cfg_load  = 1'b1;
            cfg_pos1  = 5'(v.c1);
            cfg_pos2  = 5'(v.c2);
            cfg_pos3  = 5'(v.c3);
            in_valid  = 1'b1;
            in_letter = 5'd9;
            #1 chk($sformatf("v%0d in_ready_during_cfg", idx), int'(in_ready), 0);
            @(negedge clk);
            cfg_load = 1'b0;
            in_valid = 1'b0;
        end
        in_valid  = 1'b1;
        in_letter = 5'(v.letter);
        #1 chk($sformatf("v%0d in_ready_idle", idx), int'(in_ready), 1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_letter = 5'd0;
        lat = 0;
        nlu = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lu_en) begin
                if (nlu < 3) begin
                    lin[nlu]  = int'(lu_in);
                    lrot[nlu] = int'(lu_rot);
                    lsel[nlu] = int'(lu_sel);
                end
                nlu++;
            end
        end
        chk($sformatf("v%0d latency", idx), lat, ok ? 4 : 1);
        chk($sformatf("v%0d lu_en_cycles", idx), nlu, ok ? 3 : 0);
        if (ok && nlu == 3) begin
            chk($sformatf("v%0d lu_in0", idx), lin[0], v.letter);
            chk($sformatf("v%0d lu_in1", idx), lin[1], v.s1);
            chk($sformatf("v%0d lu_in2", idx), lin[2], v.s2);
            chk($sformatf("v%0d lu_rot0", idx), lrot[0], v.p1);
            chk($sformatf("v%0d lu_rot1", idx), lrot[1], v.p2);
            chk($sformatf("v%0d lu_rot2", idx), lrot[2], v.p3);
            chk($sformatf("v%0d lu_sel", idx), lsel[0] * 16 + lsel[1] * 4 + lsel[2], 6);
        end
        chk($sformatf("v%0d out_letter", idx), int'(out_letter), v.res);
        chk($sformatf("v%0d out_err", idx), int'(out_err), v.err);
        chk($sformatf("v%0d pos1", idx), int'(pos1), v.p1);
        chk($sformatf("v%0d pos2", idx), int'(pos2), v.p2);
        chk($sformatf("v%0d pos3", idx), int'(pos3), v.p3);
        chk($sformatf("v%0d in_ready_done", idx), int'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid_drop", idx), int'(out_valid), 0);
        chk($sformatf("v%0d in_ready_back", idx), int'(in_ready), 1);
    endtask

    initial begin
        int lat, hi;
        //        cfg  c1  c2  c3 let  p1  p2  p3  s1  s2 res err
        vecs[0] = '{1'b0,  0,  0,  0,  5,  1,  0,  0,  6,  6,  6, 0};
        vecs[1] = '{1'b1, 25,  0,  0, 26,  0,  0,  0, 26, 26, 26, 0};
        vecs[2] = '{1'b1, 16,  3,  7,  2, 17,  4,  7, 19, 23,  4, 0};
        vecs[3] = '{1'b0,  0,  0,  0,  2, 18,  5,  8, 20, 25,  7, 0};
        vecs[4] = '{1'b1, 16,  4,  0, 10, 17,  5,  1,  1,  6,  7, 0};
        vecs[5] = '{1'b1, 30, 31, 26,  0,  4,  5,  0,  0,  0,  0, 1};
        vecs[6] = '{1'b0,  0,  0,  0, 27,  4,  5,  0,  0,  0,  0, 1};
        vecs[7] = '{1'b1, 25, 25, 25,  3,  0, 25, 25,  3,  2,  1, 0};
        vecs[8] = '{1'b1,  3,  4, 25, 13,  4,  5,  0, 17, 22, 22, 0};

        // reset state
        #12;
        chk("rst pos", int'(pos1) + int'(pos2) + int'(pos3), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_letter", int'(out_letter), 0);
        chk("rst out_err", int'(out_err), 0);
        chk("rst lu_en", int'(lu_en), 0);
        chk("rst lu_bus", int'(lu_sel) + int'(lu_in) + int'(lu_rot), 0);
        chk("rst in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // early out_ready must not matter
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("early out_ready", int'(out_valid), 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // backpressure: positions (4,5,0), letter 5 -> pos (5,5,0), result 15
        @(negedge clk);
        in_valid  = 1'b1;
        in_letter = 5'd5;
        @(negedge clk);
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", lat, 4);
        for (int k = 0; k < 10; k++) begin
            in_valid  = k[0];
            in_letter = 5'd9;
            cfg_load  = k[1];
            cfg_pos1  = 5'd11;
            cfg_pos2  = 5'd12;
            cfg_pos3  = 5'd13;
            #1;
            chk($sformatf("bp in_ready c%0d", k), int'(in_ready), 0);
            @(negedge clk);
            chk($sformatf("bp hold c%0d", k),
                int'(out_valid) * 1000 + int'(out_letter) * 10 + int'(out_err), 1150);
            chk($sformatf("bp pos c%0d", k),
                int'(pos1) * 10000 + int'(pos2) * 100 + int'(pos3), 50500);
        end
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release", int'(out_valid), 0);
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            hi += int'(out_valid) + int'(lu_en);
        end
        chk("bp no ghost letter", hi, 0);

        // reset during F2
        in_valid  = 1'b1;
        in_letter = 5'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid F2 reached", int'(lu_en) * 10 + int'(lu_sel), 11);
        rst_n = 1'b0;
        #1;
        chk("mid rst pos", int'(pos1) + int'(pos2) + int'(pos3), 0);
        chk("mid rst lu_en", int'(lu_en), 0);
        chk("mid rst out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid rst in_ready", int'(in_ready), 1);
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            hi += int'(out_valid) + int'(lu_en);
        end
        chk("mid rst no out_valid", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
